// File: rtl/mem_1r1w_masked_48x64_ctrl.sv
// Controller for a 48x64 1R1W byte-masked memory: zero-fill sweep after reset,
// round-robin arbitration of two masked writers, and a 1-cycle read port.
module mem_1r1w_masked_48x64_ctrl #(
  parameter int DEPTH     = 48,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int MW        = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset,
  output logic             init_done,
  input  logic             wr0_valid,
  output logic             wr0_ready,
  input  logic [AW-1:0]    wr0_addr,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic [MW-1:0]    wr0_mask,
  input  logic             wr1_valid,
  output logic             wr1_ready,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic [MW-1:0]    wr1_mask,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_resp_valid,
  output logic [WIDTH-1:0] rd_resp_data,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic [WIDTH-1:0] W0_data,
  output logic [MW-1:0]    W0_mask,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  input  logic [WIDTH-1:0] R0_data
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] init_ptr;
  logic          rr_last;
  logic          rd_accept;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= INIT;
      init_ptr      <= '0;
      rr_last       <= 1'b1;
      rd_resp_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_resp_valid <= rd_accept;
      if (state_q == INIT && init_ptr != LAST_ADDR) init_ptr <= init_ptr + 1'b1;
      if (wr0_ready)      rr_last <= 1'b0;
      else if (wr1_ready) rr_last <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_ptr == LAST_ADDR) state_d = RUN;
  end

  // All strobes are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    wr0_ready = 1'b0;
    wr1_ready = 1'b0;
    rd_ready  = 1'b0;
    rd_accept = 1'b0;
    W0_en     = 1'b0;
    W0_addr   = '0;
    W0_data   = '0;
    W0_mask   = '0;
    R0_en     = 1'b0;
    R0_addr   = '0;
    if (!reset) begin
      if (state_q == INIT) begin
        W0_en   = 1'b1;
        W0_addr = init_ptr;
        W0_mask = '1;
      end else begin
        wr0_ready = wr0_valid & (~wr1_valid | rr_last);
        wr1_ready = wr1_valid & (~wr0_valid | ~rr_last);
        if (wr0_ready) begin
          W0_en = 1'b1; W0_addr = wr0_addr; W0_data = wr0_data; W0_mask = wr0_mask;
        end else if (wr1_ready) begin
          W0_en = 1'b1; W0_addr = wr1_addr; W0_data = wr1_data; W0_mask = wr1_mask;
        end
        // A zero-mask write leaves the entry untouched, so it cannot make the read ambiguous.
        rd_ready  = ~(W0_en && W0_addr == rd_addr && W0_mask != '0);
        rd_accept = rd_valid & rd_ready;
        R0_en     = rd_accept;
        R0_addr   = rd_accept ? rd_addr : '0;
      end
    end
  end

  assign init_done    = (state_q == RUN);
  assign rd_resp_data = R0_data;

endmodule

// File: tb/tb_mem_1r1w_masked_48x64_ctrl.sv
// Randomized bench: behavioural memory behind the controller plus a reference
// model of expected contents, arbitration order and read responses.
module tb_mem_1r1w_masked_48x64_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic        wr0_valid = 0, wr1_valid = 0, rd_valid = 0;
  logic        wr0_ready, wr1_ready, rd_ready;
  logic [5:0]  wr0_addr = 0, wr1_addr = 0, rd_addr = 0;
  logic [63:0] wr0_data = 0, wr1_data = 0;
  logic [7:0]  wr0_mask = 0, wr1_mask = 0;
  logic        rd_resp_valid;
  logic [63:0] rd_resp_data;
  logic [5:0]  W0_addr, R0_addr;
  logic        W0_en, R0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;
  logic [63:0] R0_data;

  always #5 clock = ~clock;

  mem_1r1w_masked_48x64_ctrl dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr0_mask(wr0_mask),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .wr1_mask(wr1_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  // Memory macro stand-in: read returns pre-write contents one cycle later.
  logic [63:0] mem [48];
  always @(posedge clock) begin
    if (R0_en && R0_addr < 48) R0_data <= mem[R0_addr];
    if (W0_en && W0_addr < 48)
      for (int l = 0; l < 8; l++)
        if (W0_mask[l]) mem[W0_addr][l*8 +: 8] <= W0_data[l*8 +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  // Reference model state
  bit          m_run = 0, m_pend = 0;
  int          m_ptr = 0;
  int          m_last = 1;
  logic [63:0] m_resp = 0;
  logic [63:0] ref_mem [48];
  logic [63:0] last_resp;
  bit          obs_g0, obs_rd_ready, obs_resp_valid;

  task automatic step();
    bit g0, g1, gw, rr, acc;
    logic [5:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wm;
    @(negedge clock);
    g0 = 0; g1 = 0; gw = 0; wa = 0; wd = 0; wm = 0;
    if (!reset && !m_run) begin
      gw = 1; wa = 6'(m_ptr); wm = 8'hFF;
    end else if (!reset) begin
      if (wr0_valid && wr1_valid) begin
        if (m_last == 0) g1 = 1; else g0 = 1;
      end else begin
        g0 = wr0_valid; g1 = wr1_valid;
      end
      if (g0) begin gw = 1; wa = wr0_addr; wd = wr0_data; wm = wr0_mask; end
      if (g1) begin gw = 1; wa = wr1_addr; wd = wr1_data; wm = wr1_mask; end
    end
    rr  = !reset && m_run && !(gw && wa == rd_addr && wm != 0);
    acc = rr && rd_valid;
    chk("wr0_ready", wr0_ready, g0);
    chk("wr1_ready", wr1_ready, g1);
    chk("rd_ready", rd_ready, rr);
    chk("W0_en", W0_en, gw);
    if (gw) begin
      chk("W0_addr", W0_addr, wa);
      chk("W0_data", W0_data, wd);
      chk("W0_mask", W0_mask, wm);
    end
    chk("R0_en", R0_en, acc);
    if (acc) chk("R0_addr", R0_addr, rd_addr);
    chk("init_done", init_done, m_run);
    chk("rd_resp_valid", rd_resp_valid, m_pend);
    if (m_pend) chk("rd_resp_data", rd_resp_data, m_resp);
    obs_g0 = wr0_ready; obs_rd_ready = rd_ready; obs_resp_valid = rd_resp_valid;
    if (rd_resp_valid) last_resp = rd_resp_data;
    @(posedge clock);
    if (reset) begin
      m_run = 0; m_ptr = 0; m_last = 1; m_pend = 0;
    end else if (!m_run) begin
      ref_mem[m_ptr] = 0;
      m_pend = 0;
      if (m_ptr == 47) m_run = 1; else m_ptr++;
    end else begin
      m_pend = acc;
      if (acc) m_resp = ref_mem[rd_addr];
      if (gw) begin
        for (int l = 0; l < 8; l++)
          if (wm[l]) ref_mem[wa][l*8 +: 8] = wd[l*8 +: 8];
        m_last = g1 ? 1 : 0;
      end
    end
    #1;
  endtask

  task automatic set_wr0(input bit v, input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
    wr0_valid = v; wr0_addr = a; wr0_data = d; wr0_mask = m;
  endtask

  initial begin
    @(posedge clock); #1;
    step(); step();
    reset = 0;
    repeat (60) step();

    last_resp = '1;
    rd_valid = 1; rd_addr = 47; step();
    rd_valid = 0; step();
    chk("rd47_zero", last_resp, 64'h0);

    // Contention from an idle RUN start
    for (int i = 0; i < 8; i++) begin
      wr0_valid = 1; wr1_valid = 1;
      wr0_addr = 6'($urandom_range(0, 47)); wr1_addr = 6'($urandom_range(0, 47));
      wr0_data = {$urandom, $urandom}; wr1_data = {$urandom, $urandom};
      wr0_mask = 8'($urandom); wr1_mask = 8'($urandom);
      step();
    end
    wr0_valid = 0; step();
    wr0_valid = 1; step();
    chk("contend_wr0", obs_g0, 1'b1);
    wr0_valid = 0; wr1_valid = 0;

    set_wr0(1, 5, 64'h1122334455667788, 8'hFF); step();
    set_wr0(1, 5, 64'hFFFFFFFFFFFFFFFF, 8'h0F); step();
    wr0_valid = 0; rd_valid = 1; rd_addr = 5; step();
    rd_valid = 0; step();
    chk("mask_merge", last_resp, 64'h11223344FFFFFFFF);

    set_wr0(1, 9, 64'hA5A5A5A5A5A5A5A5, 8'hFF); rd_valid = 1; rd_addr = 9; step();
    chk("coll_stall", obs_rd_ready, 1'b0);
    wr0_valid = 0; step();
    chk("coll_accept", obs_rd_ready, 1'b1);
    rd_valid = 0; step();
    chk("coll_data", last_resp, 64'hA5A5A5A5A5A5A5A5);
    set_wr0(1, 9, 64'hA5A5A5A5A5A5A5A5, 8'hFF); rd_valid = 1; rd_addr = 10; step();
    chk("no_coll", obs_rd_ready, 1'b1);
    wr0_valid = 0; rd_valid = 0; step();

    for (int i = 0; i < 8; i++) begin
      set_wr0(1, 6'(i), 64'(i), 8'hFF); step();
    end
    wr0_valid = 0;
    for (int i = 0; i < 9; i++) begin
      rd_valid = (i < 8); rd_addr = 6'(i % 8);
      step();
      if (i > 0) begin
        chk("b2b_valid", obs_resp_valid, 1'b1);
        chk("b2b_data", last_resp, 64'(i - 1));
      end
    end
    rd_valid = 0;

    for (int i = 0; i < 400; i++) begin
      wr0_valid = 1'($urandom); wr1_valid = 1'($urandom); rd_valid = 1'($urandom);
      wr0_addr = 6'($urandom_range(0, 7)); wr1_addr = 6'($urandom_range(0, 7));
      rd_addr  = 6'($urandom_range(0, 7));
      if (i % 3 == 0) rd_addr = 6'($urandom_range(0, 47));
      wr0_data = {$urandom, $urandom}; wr1_data = {$urandom, $urandom};
      wr0_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      wr1_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    wr0_valid = 0; wr1_valid = 0; rd_valid = 0;

    // Reset partway through the sweep, then during an in-flight read
    reset = 1; step(); reset = 0;
    repeat (20) step();
    reset = 1; step(); reset = 0;
    repeat (47) step();
    chk("init_low_47", init_done, 1'b0);
    repeat (3) step();
    chk("init_high", init_done, 1'b1);
    rd_valid = 1; rd_addr = 3; step();
    rd_valid = 0; reset = 1; step();
    reset = 0; step();
    chk("resp_dropped", obs_resp_valid, 1'b0);
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_masked_48x64_ctrl.md
Name: mem_1r1w_masked_48x64_ctrl

Overview:
- Controller in front of one mem_1r1w_masked_48x64 instance.
- After reset it zero-initialises all 48 entries.
- It then round-robin arbitrates two masked-write requesters onto W0 and serves one read requester on R0 with a fixed 1-cycle response.
- It blocks a read that collides with a same-cycle write to the same address, so read data is never ambiguous.

Parameters:
- DEPTH, 48, number of memory entries; address width is ceil(log2(DEPTH)) = 6.
- WIDTH, 64, data width in bits.
- MASK_GRAN, 8, bits per mask lane; mask width is WIDTH/MASK_GRAN = 8.

Ports:
- clock  in  1  single clock for controller and memory (top ties R0_clk/W0_clk to it).
- reset  in  1  synchronous, active-high.
- init_done  out  1  high once initialisation sweep is complete.
- wr0_valid  in  1  requester 0 write request.
- wr0_ready  out  1  requester 0 write accepted this cycle.
- wr0_addr  in  6  requester 0 write address.
- wr0_data  in  64  requester 0 write data.
- wr0_mask  in  8  requester 0 byte-lane mask.
- wr1_valid  in  1  requester 1 write request.
- wr1_ready  out  1  requester 1 write accepted this cycle.
- wr1_addr  in  6  requester 1 write address.
- wr1_data  in  64  requester 1 write data.
- wr1_mask  in  8  requester 1 byte-lane mask.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  6  read address.
- rd_resp_valid  out  1  read data valid, exactly 1 cycle after acceptance.
- rd_resp_data  out  64  read data.
- W0_addr  out  6  memory write address.
- W0_en  out  1  memory write enable.
- W0_data  out  64  memory write data.
- W0_mask  out  8  memory byte-write enable.
- R0_addr  out  6  memory read address.
- R0_en  out  1  memory read enable.
- R0_data  in  64  memory read data, valid 1 cycle after R0_en.

Behaviour:
- States: INIT, RUN.
- Reset (synchronous, active-high, sampled on clock edge):
  - state=INIT, init_ptr=0, rr_last=1 (requester 0 has first priority).
  - init_done=0, rd_resp_valid=0, all ready outputs 0, W0_en=0, R0_en=0.
- Reset asserted mid-operation: same values next cycle and a full re-sweep. Any read response in flight is dropped; rd_resp_valid=0 the cycle after reset.
- INIT:
  - Each cycle: W0_en=1, W0_addr=init_ptr, W0_data=0, W0_mask=8'hFF, init_ptr++.
  - wr0_ready, wr1_ready and rd_ready are all 0.
  - When init_ptr==DEPTH-1 is written, next state is RUN and init_done=1 from that next cycle.
  - Sweep length: exactly 48 cycles; init_done rises on cycle 49 after reset deasserts.
  - init_ptr never wraps past 47.
- RUN, write arbitration (combinational grant, registered rr_last):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to rr_last.
  - On a grant: wrN_ready=1, W0_en=1, W0_addr/W0_data/W0_mask = requester's fields, rr_last=N next cycle.
  - No valid: W0_en=0, rr_last unchanged.
  - wrN_ready depends only on valids and rr_last, never on readiness of the other port.
- RUN, mask: a write with mask==0 is still granted and consumes the slot; W0_en=1 with W0_mask=0.
- RUN, read:
  - rd_ready=1 unless the granted write this cycle has W0_addr==rd_addr and W0_mask!=0 (collision stall).
  - Accept = rd_valid & rd_ready. Then R0_en=1, R0_addr=rd_addr.
  - On accept, rd_resp_valid=1 next cycle with rd_resp_data=R0_data.
  - On a stall, R0_en=0; the requester holds the request. Next cycle the read returns post-write data.
  - Back-to-back reads: one per cycle, responses in order, no bubbles.
- Address out of range (addr>=48), read or write: accepted; the memory result is undefined; the controller takes no other action.
- No outputs depend combinationally on R0_data except rd_resp_data.

Test Plan:
- Reset then idle 60 cycles -> W0_en high cycles 1..48 with addresses 0..47, data 0, mask FF; init_done=1 from cycle 49; then read addr 47 -> rd_resp_data=0.
- wr0 and wr1 both valid continuously from RUN start -> grants alternate 0,1,0,1 for 8 cycles; after a single wr1-only grant, next contention goes to wr0.
- Write addr 5 data 0x1122334455667788 mask FF, then addr 5 data 0xFFFF...FF mask 0x0F, read 5 -> 0x11223344FFFFFFFF.
- Read addr 9 in same cycle as granted write addr 9 data 0xA5A5... mask FF -> rd_ready=0 that cycle; next cycle accepted; response = 0xA5A5...; read addr 10 with same write -> accepted immediately.
- Reads every cycle at addrs 0..7 after writes of value=addr -> rd_resp_valid high 8 consecutive cycles, data 0..7 in order, 1-cycle latency.
- Assert reset at sweep cycle 20 and during an in-flight read in RUN -> init restarts at addr 0, rd_resp_valid=0 next cycle, init_done low until a full 48-cycle sweep completes.
